// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters and the eight-way arbiter.
interface rr_arbiter8_if;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    // Requester side drives en/req and observes the grant.
    modport master (
        output en,
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_valid,
        input  timeout
    );

    // Arbiter side.
    modport slave (
        input  en,
        input  req,
        output gnt,
        output gnt_id,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter8.sv
// Eight-requester arbiter: fixed or round-robin priority, one grant at a time,
// grant held until release or MAX_HOLD expiry, idle cycle between grants.
module rr_arbiter8 #(
    parameter bit          RR_EN    = 1'b1,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arbiter8_if.slave bus
);

    localparam int unsigned NW = 8;
    localparam int unsigned IW = 3;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);
    localparam bit            HOLD_ON  = (MAX_HOLD != 0);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [NW-1:0] gnt_q, gnt_nxt;
    logic [IW-1:0] id_q, id_nxt;
    logic          valid_q, valid_nxt;
    logic          tmo_q, tmo_nxt;
    logic [IW-1:0] ptr_q, ptr_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;

    logic          win_any_c;
    logic [IW-1:0] win_id_c;
    logic [IW-1:0] idx_c;

    // Search ptr, ptr-1, ... (mod 8); the first set request wins.
    always_comb begin
        win_any_c = 1'b0;
        win_id_c  = ptr_q;
        idx_c     = ptr_q;
        for (int o = int'(NW) - 1; o >= 0; o--) begin
            idx_c = ptr_q - IW'(o);
            if (bus.req[idx_c]) begin
                win_any_c = 1'b1;
                win_id_c  = idx_c;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_q;
        id_nxt    = id_q;
        valid_nxt = valid_q;
        tmo_nxt   = 1'b0;
        ptr_nxt   = ptr_q;
        cnt_nxt   = cnt_q;
        unique case (state)
            IDLE: begin
                gnt_nxt   = '0;
                valid_nxt = 1'b0;
                if (bus.en && win_any_c) begin
                    gnt_nxt   = NW'(1) << win_id_c;
                    id_nxt    = win_id_c;
                    valid_nxt = 1'b1;
                    cnt_nxt   = CW'(1);
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!bus.req[id_q] || (HOLD_ON && (cnt_q == HOLD_LIM))) begin
                    // Release takes precedence over the hold limit.
                    tmo_nxt   = bus.req[id_q];
                    gnt_nxt   = '0;
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                    if (RR_EN) begin
                        ptr_nxt = id_q - IW'(1);
                    end
                end else if (cnt_q != CNT_MAX) begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
            ptr_q   <= '1;
            cnt_q   <= '0;
        end else begin
            state   <= state_nxt;
            gnt_q   <= gnt_nxt;
            id_q    <= id_nxt;
            valid_q <= valid_nxt;
            tmo_q   <= tmo_nxt;
            ptr_q   <= ptr_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = id_q;
    assign bus.gnt_valid = valid_q;
    assign bus.timeout   = tmo_q;

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
Eight-requester bus/resource arbiter built around an 8-to-3 priority-encoding search. It grants one requester at a time and holds the grant until the requester releases or a hold timeout expires. Priority is either fixed (bit 7 highest, same ordering as the 8-to-3 priority encoder) or round-robin. It sits in front of any shared single-port resource in the combinational/sequential library.

Parameters:
RR_EN, 1, 1 = round-robin rotation; 0 = fixed priority (bit 7 highest).
MAX_HOLD, 16, maximum consecutive grant cycles per grant; 0 = unlimited. Legal range 0..255; the hold counter is 8 bits.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  reset; asynchronous, active-low.
en  input  1  arbitration enable; gates new grants only.
req  input  8  request vector; req[i] high = requester i wants the resource.
gnt  output  8  one-hot grant, registered.
gnt_id  output  3  binary index of the granted requester; valid when gnt_valid=1.
gnt_valid  output  1  high while any grant is active (equals |gnt).
timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (rst_n=0, takes effect immediately without a clock edge): gnt=0, gnt_id=0, gnt_valid=0, timeout=0, state=IDLE, ptr=7, hold_cnt=0. Reset mid-grant drops the grant at once.
- States: IDLE and GRANT.
- Search order: ptr, ptr-1, ..., ptr-7, all mod 8. The first set req bit in that order wins. With RR_EN=0, ptr is fixed at 7, so the search is a pure priority encode with bit 7 highest.
- IDLE: if en=1 and req!=0, the winner k is registered on the next edge: gnt=1<<k, gnt_id=k, gnt_valid=1, hold_cnt=1, state=GRANT. The latency from req sampled to gnt high is 1 cycle. If en=0 or req=0, stay in IDLE with outputs at 0.
- GRANT, release: if req[gnt_id]=0 at an edge, then gnt=0, gnt_valid=0, state=IDLE.
- GRANT, timeout: if MAX_HOLD!=0 and hold_cnt==MAX_HOLD and req[gnt_id]=1, revoke on that edge. Set gnt=0, gnt_valid=0, timeout=1 for exactly one cycle, state=IDLE. A requester therefore holds gnt for at most MAX_HOLD cycles.
- GRANT, otherwise: hold the grant and increment hold_cnt. The counter saturates at 255 when MAX_HOLD=0.
- Pointer update: when any grant to k ends (release or timeout) and RR_EN=1, ptr=(k-1) mod 8, so k becomes lowest priority.
- IDLE gap: at least one cycle with gnt=0 always separates consecutive grants. Grants are never back-to-back.
- Requests other than req[gnt_id] are ignored during GRANT. gnt_id keeps its last value in IDLE. gnt is never multi-hot.
- en=0 during GRANT does not affect the current grant. It only blocks the IDLE->GRANT transition.
- Simultaneous release and hold_cnt==MAX_HOLD: the release wins and timeout stays 0.
- req changes in the same cycle as arbitration: the value sampled at the edge decides.

Test Plan:
- Fixed priority: RR_EN=0, en=1, req=8'b01010101 held. Expect gnt=8'b01000000, gnt_id=6, gnt_valid=1 one cycle after req. Then req=8'b00010101 (6 released): gnt=0 for one cycle, then gnt_id=4.
- Round-robin fairness: RR_EN=1, req=8'hFF. Each granted requester drops its bit for 1 cycle after 2 grant cycles, then re-asserts. Expect grant order 7,6,5,4,3,2,1,0,7 with exactly one idle cycle between grants.
- Timeout: MAX_HOLD=4, req=8'b00001001 held. Expect gnt_id=3 for exactly 4 cycles, then timeout=1 for 1 cycle with gnt=0. Next grant is gnt_id=0 (RR_EN=1), or gnt_id=3 again (RR_EN=0).
- No request and enable gating: req=8'h00 gives gnt_valid=0 indefinitely. With req=8'h11 and en=0, no grant. Raise en to 1 and gnt_id=4 appears 1 cycle later. Dropping en during that grant leaves gnt unchanged.
- Async reset mid-grant: while gnt_id=5, pulse rst_n low between clock edges. gnt, gnt_valid and timeout go to 0 immediately. After release with req=8'h81, gnt_id=7 (ptr reset to 7).
- Release/timeout collision: MAX_HOLD=2, req[2] drops on the edge where hold_cnt==2. Expect gnt=0 and timeout stays 0.
